// File: rtl/pipe_stage_if.sv
// Handshake bundle for one pipeline stage boundary: upstream/downstream
// payload handshake plus hazard freeze, branch flush and occupancy.
interface pipe_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             freeze;
    logic             flush;
    logic [1:0]       count;

    // Environment side: feeds payload, consumes head, drives hazard controls
    modport master (
        output in_valid, in_data, out_ready, freeze, flush,
        input  in_ready, out_valid, out_data, count
    );

    // Stage side
    modport slave (
        input  in_valid, in_data, out_ready, freeze, flush,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready handshake, freeze, flush and
// an optional skid entry that breaks the out_ready -> in_ready path.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{1'b0}},
    parameter bit               SKID_EN   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    pipe_stage_if.slave  bus
);
    logic             main_valid, main_valid_n;
    logic [WIDTH-1:0] main_data,  main_data_n;
    logic             skid_valid, skid_valid_n;
    logic [WIDTH-1:0] skid_data,  skid_data_n;

    logic out_valid_c;
    logic out_fire;
    logic in_ready_c;
    logic in_fire;

    assign out_valid_c = main_valid & ~bus.freeze;
    assign out_fire    = out_valid_c & bus.out_ready;

    // With a skid entry, readiness depends only on local state
    assign in_ready_c = SKID_EN ? (~skid_valid & ~bus.freeze & ~bus.flush)
                                : ((~main_valid | bus.out_ready) & ~bus.freeze & ~bus.flush);
    assign in_fire    = bus.in_valid & in_ready_c;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = main_data;
    assign bus.count     = 2'(main_valid) + 2'(skid_valid);

    // Next-state: flush > freeze > drain skid > refill main > fill skid
    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        if (bus.flush) begin
            main_valid_n = 1'b0;
            main_data_n  = FLUSH_VAL;
            skid_valid_n = 1'b0;
            skid_data_n  = FLUSH_VAL;
        end else if (bus.freeze) begin
            main_valid_n = main_valid;
        end else if (skid_valid) begin
            if (out_fire) begin
                main_valid_n = 1'b1;
                main_data_n  = skid_data;
                skid_valid_n = 1'b0;
            end
        end else if (~main_valid | out_fire) begin
            main_valid_n = in_fire;
            if (in_fire) begin
                main_data_n = bus.in_data;
            end
        end else if (in_fire) begin
            skid_valid_n = 1'b1;
            skid_data_n  = bus.in_data;
        end
    end

    // Skid registers collapse to constants when the skid is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= FLUSH_VAL;
            skid_valid <= 1'b0;
            skid_data  <= FLUSH_VAL;
        end else begin
            main_valid <= main_valid_n;
            main_data  <= main_data_n;
            skid_valid <= SKID_EN ? skid_valid_n : 1'b0;
            skid_data  <= SKID_EN ? skid_data_n  : FLUSH_VAL;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table on a skid-enabled stage,
// plus hand sequences for async reset and the single-entry variant.
module tb_pipe_stage_reg;
    logic clk;
    logic rst;

    pipe_stage_if #(.WIDTH(8)) ia ();
    pipe_stage_if #(.WIDTH(8)) ib ();

    pipe_stage_reg #(.WIDTH(8), .FLUSH_VAL(8'hEE), .SKID_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia)
    );
    pipe_stage_reg #(.WIDTH(8), .FLUSH_VAL(8'hCC), .SKID_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fz;
        logic       fl;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ir;
        logic [1:0] e_cnt;
    } vec_t;

    localparam int unsigned NVEC = 19;
    vec_t vecs [NVEC];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // {iv, d, out_ready, freeze, flush, exp out_valid, out_data, in_ready, count}
        vecs[0]  = '{1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE, 1'b1, 2'd0};
        vecs[1]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 2'd1};
        vecs[4]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 2'd0};
        vecs[5]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 2'd1};
        vecs[6]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 2'd2};
        vecs[7]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 2'd2};
        vecs[8]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd1};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b1, 2'd1};
        vecs[10] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA2, 1'b1, 2'd0};
        vecs[11] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 2'd1};
        vecs[12] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 2'd1};
        vecs[13] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 2'd1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 2'd1};
        vecs[15] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 2'd0};
        vecs[16] = '{1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 2'd1};
        vecs[17] = '{1'b1, 8'h79, 1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 2'd2};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE, 1'b1, 2'd0};

        ia.in_valid = 1'b0; ia.in_data = 8'h00; ia.out_ready = 1'b0; ia.freeze = 1'b0; ia.flush = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = 8'h00; ib.out_ready = 1'b0; ib.freeze = 1'b0; ib.flush = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.a.out_valid", 32'(ia.out_valid), 32'h0);
        chk("rst.a.out_data",  32'(ia.out_data),  32'hEE);
        chk("rst.a.count",     32'(ia.count),     32'h0);
        chk("rst.a.in_ready",  32'(ia.in_ready),  32'h1);
        chk("rst.b.out_data",  32'(ib.out_data),  32'hCC);
        chk("rst.b.count",     32'(ib.count),     32'h0);
        rst = 1'b0;

        // Table: inputs applied just after an edge, outputs sampled mid-cycle
        for (int i = 0; i < int'(NVEC); i++) begin
            ia.in_valid  = vecs[i].iv;
            ia.in_data   = vecs[i].d;
            ia.out_ready = vecs[i].ordy;
            ia.freeze    = vecs[i].fz;
            ia.flush     = vecs[i].fl;
            #2;
            chk($sformatf("v%0d.out_valid", i), 32'(ia.out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d.out_data", i),  32'(ia.out_data),  32'(vecs[i].e_od));
            chk($sformatf("v%0d.in_ready", i),  32'(ia.in_ready),  32'(vecs[i].e_ir));
            chk($sformatf("v%0d.count", i),     32'(ia.count),     32'(vecs[i].e_cnt));
            @(posedge clk);
            #1;
        end

        // Async reset between edges while two entries are held
        ia.in_valid = 1'b1; ia.in_data = 8'hB0; ia.out_ready = 1'b0; ia.freeze = 1'b0; ia.flush = 1'b0;
        @(posedge clk); #1;
        ia.in_data = 8'hB1;
        @(posedge clk); #1;
        chk("arst.pre.count", 32'(ia.count), 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("arst.count",     32'(ia.count),     32'h0);
        chk("arst.out_data",  32'(ia.out_data),  32'hEE);
        chk("arst.out_valid", 32'(ia.out_valid), 32'h0);
        ia.in_data = 8'hC0;
        #1 rst = 1'b0;
        #1;
        chk("arst.rel.count", 32'(ia.count), 32'h0);
        @(posedge clk); #1;
        chk("arst.first.out_data",  32'(ia.out_data),  32'hC0);
        chk("arst.first.count",     32'(ia.count),     32'h1);
        chk("arst.first.out_valid", 32'(ia.out_valid), 32'h1);
        ia.in_valid = 1'b0; ia.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("arst.drain.count", 32'(ia.count), 32'h0);

        // Single-entry variant: in_ready follows out_ready in the same cycle
        ib.in_valid = 1'b1; ib.in_data = 8'h31; ib.out_ready = 1'b0;
        #1;
        chk("b.empty.in_ready", 32'(ib.in_ready), 32'h1);
        @(posedge clk); #1;
        ib.in_data = 8'h32;
        #1;
        chk("b.full.in_ready", 32'(ib.in_ready), 32'h0);
        chk("b.full.out_data", 32'(ib.out_data), 32'h31);
        chk("b.full.count",    32'(ib.count),    32'h1);
        ib.out_ready = 1'b1;
        #1;
        chk("b.rdy.in_ready",  32'(ib.in_ready),  32'h1);
        chk("b.rdy.out_valid", 32'(ib.out_valid), 32'h1);
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
        #1;
        chk("b.repl.out_data",  32'(ib.out_data),  32'h32);
        chk("b.repl.count",     32'(ib.count),     32'h1);
        chk("b.repl.out_valid", 32'(ib.out_valid), 32'h1);
        @(posedge clk); #1;
        chk("b.drain.count", 32'(ib.count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
